// File: rtl/pla_eval_pipe.sv
// pla_eval_pipe: run-time programmable sum-of-products evaluator behind a 2-stage valid/ready pipeline
module pla_eval_pipe #(
  parameter int N_IN = 25,
  parameter int N_TERMS = 16,
  parameter int N_OUT = 1,
  localparam int TA_W = $clog2(N_TERMS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  output logic            cfg_ready,
  input  logic [TA_W-1:0] cfg_addr,
  input  logic            cfg_en,
  input  logic [N_IN-1:0] cfg_care,
  input  logic [N_IN-1:0] cfg_pol,
  input  logic [N_OUT-1:0] cfg_or,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_OUT-1:0] out_y
);
  logic [N_TERMS-1:0] t, s1_t;
  logic [N_TERMS-1:0][N_OUT-1:0] tm;
  logic [N_OUT-1:0] y;
  logic s1_v, ld2, acc;
  assign cfg_ready = ~s1_v & ~out_valid;
  assign ld2 = ~out_valid | out_ready;
  assign in_ready = ~cfg_we & (~s1_v | ld2);
  assign acc = in_valid & in_ready;
  for (genvar k = 0; k < N_TERMS; k++) begin : g_term
    logic en;
    logic [N_IN-1:0] care, pol;
    logic [N_OUT-1:0] orv;
    assign t[k] = en & (&(~care | ~(in_x ^ pol)));
    assign tm[k] = s1_t[k] ? orv : '0;
    // Plane entry k; an address outside the term range matches no entry, so the write is dropped
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        en <= 1'b0;
        care <= '0;
        pol <= '0;
        orv <= '0;
      end else if (cfg_we & cfg_ready & (cfg_addr == TA_W'(k))) begin
        en <= cfg_en;
        care <= cfg_care;
        pol <= cfg_pol;
        orv <= cfg_or;
      end
  end
  // OR plane over the term bits captured in stage 1
  always_comb begin
    y = '0;
    for (int k = 0; k < N_TERMS; k++) y = y | tm[k];
  end
  // Stage 1 holds term bits, stage 2 holds the result; out_y only moves when a real vector lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_t <= '0;
      out_valid <= 1'b0;
      out_y <= '0;
    end else begin
      if (acc) begin
        s1_v <= 1'b1;
        s1_t <= t;
      end else if (ld2) s1_v <= 1'b0;
      if (ld2) out_valid <= s1_v;
      if (ld2 & s1_v) out_y <= y;
    end
endmodule

// File: tb/tb_pla_eval_pipe.sv
// tb_pla_eval_pipe: scoreboard bench for pla_eval_pipe with directed and random traffic
module tb_pla_eval_pipe;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, cfg_ready, cfg_en = 0;
  logic [3:0] cfg_addr = 0;
  logic [24:0] cfg_care = 0, cfg_pol = 0, in_x = 0;
  logic [0:0] cfg_or = 0, out_y;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  int n_tests = 0, n_fail = 0, cyc = 0;
  bit m_en [16];
  logic [24:0] m_care [16], m_pol [16];
  bit m_or [16];
  bit qy [$];
  int qc [$];
  bit prev_stall = 0;
  logic [0:0] prev_y = 0;

  pla_eval_pipe dut (.clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
    .cfg_or(cfg_or), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit mf(input logic [24:0] x);
    bit y = 0;
    for (int k = 0; k < 16; k++) begin
      bit tk = m_en[k];
      for (int i = 0; i < 25; i++)
        if (m_care[k][i] && x[i] != m_pol[k][i]) tk = 0;
      if (tk && m_or[k]) y = 1;
    end
    return y;
  endfunction

  // Reference model: vectors in flight as a queue of expected results with acceptance stamps
  always @(negedge clk) begin
    if (!rst_n) begin
      qy.delete();
      qc.delete();
      for (int k = 0; k < 16; k++) begin
        m_en[k] = 0; m_care[k] = 0; m_pol[k] = 0; m_or[k] = 0;
      end
      prev_stall = 0;
    end else begin
      bit exp_cr, exp_ov, exp_ir;
      exp_cr = qy.size() == 0;
      exp_ov = qy.size() > 0 && cyc - qc[0] >= 2;
      exp_ir = !cfg_we && (qy.size() < 2 || out_ready);
      chk("cfg_ready", cfg_ready, exp_cr);
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) chk("out_y", out_y, qy[0]);
      if (prev_stall) chk("stall_hold", out_y, prev_y);
      if (exp_ov && out_ready) begin
        void'(qy.pop_front());
        void'(qc.pop_front());
      end
      if (in_valid && exp_ir) begin
        qy.push_back(mf(in_x));
        qc.push_back(cyc);
      end
      if (cfg_we && exp_cr) begin
        m_en[cfg_addr] = cfg_en; m_care[cfg_addr] = cfg_care;
        m_pol[cfg_addr] = cfg_pol; m_or[cfg_addr] = cfg_or[0];
      end
      prev_stall = exp_ov && !out_ready;
      prev_y = out_y;
    end
  end

  task automatic send(input logic [24:0] x);
    in_valid = 1; in_x = x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic cfg(input int a, input bit e, input logic [24:0] c, input logic [24:0] p, input bit o);
    cfg_we = 1; cfg_addr = 4'(a); cfg_en = e; cfg_care = c; cfg_pol = p; cfg_or = o;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    if (!cfg_ready) chk("cfg_timeout", cfg_ready, 1);
    @(posedge clk); #1 cfg_we = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_ready && qy.size() == 0) break;
    end
    chk("drain_ready", cfg_ready, 1);
    chk("drain_queue", qy.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_y(input string nm, input logic [24:0] x, input bit lit);
    drain();
    chk({nm, "_model"}, mf(x), lit);
    send(x);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, out_y, lit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    @(posedge clk); #1;
    send(25'h1FFFFFF);
    chk("lat_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_y_zero", out_y, 0);
    chk("lat_cfg_ready", cfg_ready, 0);
    cfg(0, 1, 25'h000F1800, 25'h000F1800, 1);
    expect_y("t0_hit", 25'h000F1800, 1);
    expect_y("t0_miss", 25'h000F0800, 0);
    cfg(1, 1, 25'h0, 25'h0, 1);
    expect_y("t1_const", 25'h0, 1);
    cfg(1, 0, 25'h0, 25'h0, 1);
    expect_y("t1_off", 25'h0, 0);
    expect_y("t1_off_t0", 25'h000F1800, 1);
    drain();
    fork
      for (int v = 0; v < 8; v++) send(25'h000F1800 ^ (($urandom % 2) ? 25'h0 : 25'(1) << ($urandom % 25)));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(25'h000F1800);
    send(25'h000F1800);
    cfg_we = 1; cfg_addr = 0; cfg_en = 1; cfg_care = 25'h000F1800; cfg_pol = 25'h000F1800; cfg_or = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cfg_ready", cfg_ready, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_y", out_y, 1);
    end
    @(posedge clk); #1 out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    chk("late_write_ready", cfg_ready, 1);
    @(posedge clk); #1 cfg_we = 0;
    expect_y("late_write", 25'h000F1800, 0);
    cfg(0, 1, 25'h000F1800, 25'h000F1800, 1);
    drain();
    out_ready = 0;
    send(25'h000F1800);
    send(25'h1FFFFFF);
    rst_n = 0;
    #1;
    chk("rst_mid_ov", out_valid, 0);
    chk("rst_mid_cr", cfg_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; out_ready = 1;
    expect_y("post_rst_a", 25'h000F1800, 0);
    expect_y("post_rst_b", 25'h1FFFFFF, 0);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      in_valid = $urandom % 2;
      in_x = m_pol[$urandom % 16] ^ (($urandom % 2) ? 25'h0 : 25'(1) << ($urandom % 25));
      out_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 12) == 0;
      cfg_addr = 4'($urandom % 16);
      cfg_en = ($urandom % 4) != 0;
      cfg_care = 25'($urandom & $urandom & $urandom);
      cfg_pol = 25'($urandom);
      cfg_or = 1'($urandom % 4 != 0);
    end
    @(posedge clk); #1 in_valid = 0; cfg_we = 0; out_ready = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
